// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter: NUM_REQ requesters share one uart_master transmitter, one byte at a time.
// Optional WAIT_DONE watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic [NUM_REQ-1:0]           done,
  output logic                         en_tx,
  output logic [DATA_W-1:0]            data_tx,
  input  logic                         tx_done,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         timeout_err
);

  localparam int GW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("uart_tx_arbiter: unsupported NUM_REQ or TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, RELEASE} state_t;

  state_t              state, state_nxt;
  logic [GW-1:0]       last_grant;
  logic [GW-1:0]       pick;
  logic                pick_vld;
  logic [DATA_W-1:0]   pick_data;
  logic                expire;

  // Search upward from the requester after the last completed one, wrapping around.
  always_comb begin
    pick_vld  = 1'b0;
    pick      = '0;
    pick_data = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!pick_vld && req[GW'((int'(last_grant) + i) % NUM_REQ)]) begin
        pick_vld = 1'b1;
        pick     = GW'((int'(last_grant) + i) % NUM_REQ);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == GW'(i)) pick_data = req_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wd_cnt;
  logic           tmo_q;

  // Counter sits at zero outside WAIT_DONE, so it restarts on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wd_cnt <= (state == WAIT_DONE) ? wd_cnt + 1'b1 : '0;
      tmo_q  <= expire;
    end
  end

  assign expire      = (state == WAIT_DONE) && !tx_done && (wd_cnt == WDW'(TIMEOUT_CYC - 1));
  assign timeout_err = tmo_q;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      data_tx    <= '0;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      done       <= '0;
    end else begin
      state <= state_nxt;
      done  <= '0;
      if (state == IDLE && pick_vld) begin
        data_tx  <= pick_data;
        grant_id <= pick;
      end
      if (state == WAIT_DONE && (tx_done || expire)) last_grant <= grant_id;
      if (state == WAIT_DONE && tx_done) done <= NUM_REQ'(1) << grant_id;
    end
  end

  always_comb begin
    state_nxt = state;
    en_tx     = 1'b0;
    ack       = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE:      if (pick_vld) state_nxt = LOAD;
      LOAD: begin
        en_tx     = 1'b1;
        ack       = NUM_REQ'(1) << grant_id;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (tx_done || expire) state_nxt = RELEASE;
      RELEASE:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

endmodule
